tri_fifo_writer: RTL and testbench
==================================

TRI_FIFO_WRITER -- requirements
Module: tri_fifo_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-003 SHALL have port tri_valid, input, 1 bit: upstream offers a triangle.
REQ-004 SHALL have port tri_ready, output, 1 bit: block accepts a triangle this cycle; a transfer occurs when tri_valid and tri_ready are both 1.
REQ-005 SHALL have ports tri_v0, tri_v1, tri_v2, inputs, 96 bits each: vertex words of the offered triangle.
REQ-006 SHALL have ports tri_c0, tri_c1, tri_c2, inputs, 96 bits each: color words paired with v0, v1, v2.
REQ-007 SHALL have port flush_req, input, 1 bit: single-cycle request to enqueue an end-of-frame flush marker.
REQ-008 SHALL have ports vertex_full and color_full, inputs, 1 bit each: full flags of the downstream vertex and color FIFOs.
REQ-009 SHALL have ports vertex_wr_en and color_wr_en, outputs, 1 bit each: FIFO write strobes.
REQ-010 SHALL have ports vertex_din and color_din, outputs, 96 bits each: FIFO write data.
REQ-011 SHALL have port sentinel_err, output, 1 bit: one-cycle pulse when a triangle is dropped (REQ-021).
REQ-012 SHALL have port flush_done, output, 1 bit: one-cycle pulse after the last flush-marker write.
REQ-013 SHALL have port tri_count, output, 16 bits: count of triangles fully written; wraps 16'hFFFF -> 0.

Function
REQ-014 SHALL implement states IDLE, WRITE and FLUSH, plus a 2-bit word index idx (0..2).
REQ-015 SHALL drive tri_ready = 1 only in IDLE with flush_pending = 0; tri_ready is a pure function of registered state.
REQ-016 SHALL, on a transfer, latch all six words, set idx = 0, and enter WRITE.
REQ-017 SHALL, in WRITE, assert vertex_wr_en and color_wr_en together for exactly one cycle per word pair, only in a cycle where vertex_full = 0 and color_full = 0.
- Strobes are combinational from registered state and the full inputs; they are never asserted independently.
REQ-018 SHALL, on each write in WRITE, drive vertex_din/color_din = latched v[idx]/c[idx] and increment idx; when a full flag is 1, hold idx and drive both strobes 0.
REQ-019 SHALL, on the write with idx = 2, increment tri_count and return to IDLE.
- Minimum occupancy is 3 cycles per triangle; first write occurs in the cycle after the transfer.
REQ-020 SHALL set flush_pending whenever flush_req = 1, in any state; flush_pending is cleared on entry to FLUSH.
REQ-021 SHALL, at a transfer where tri_v0 and tri_c0 both equal 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, drop the triangle.
- No writes; pulse sentinel_err in the following cycle; stay in IDLE; tri_count unchanged.
REQ-022 SHALL, in IDLE with flush_pending = 1, enter FLUSH with idx = 0.
REQ-023 SHALL, in FLUSH, write three pairs under the same full gating as WRITE, each with vertex_din = color_din = all-ones.
REQ-024 SHALL, on the third flush write, pulse flush_done in the next cycle and return to IDLE; tri_count is unchanged by a flush.
REQ-025 SHALL, when tri_valid and flush_req are both 1 in IDLE with flush_pending = 0, accept the triangle first; the flush follows immediately after that triangle's third write.
REQ-026 SHALL merge a flush_req arriving while FLUSH is in progress into one additional flush after the current one.
REQ-027 SHALL drive vertex_din and color_din to 0 whenever the strobes are 0.

Reset
REQ-028 SHALL, while reset = 0 at a rising clk, set state IDLE, idx 0, flush_pending 0, tri_count 0, latched words 0, sentinel_err 0 and flush_done 0.
REQ-029 SHALL hold tri_ready, vertex_wr_en and color_wr_en at 0 while reset = 0.
REQ-030 SHALL, on reset mid-triangle or mid-flush, abandon the sequence with no further writes; the partially written entries are the system's responsibility to clear.

Verification
REQ-031 Bench SHALL cover: one triangle with v = 1,2,3 and c = 4,5,6, FIFOs never full -> writes (1,4), (2,5), (3,6) on three consecutive cycles starting the cycle after the transfer; tri_count = 1.
REQ-032 Bench SHALL cover: color_full = 1 for 4 cycles during the second write -> no strobes and no idx change for those cycles; resumes with (2,5); vertex FIFO never written alone.
REQ-033 Bench SHALL cover: tri_valid and flush_req in the same IDLE cycle -> 3 triangle writes, then 3 all-ones pairs, then flush_done 1 cycle later; tri_count = 1.
REQ-034 Bench SHALL cover: triangle with v0 = c0 = all-ones -> no writes, sentinel_err pulse, tri_count unchanged, tri_ready 1 next cycle.
REQ-035 Bench SHALL cover: reset = 0 after the first write of a triangle -> strobes 0 from that edge; tri_ready 1 in the first cycle after reset = 1; tri_count = 0.
REQ-036 Bench SHALL cover: 65536 triangles -> tri_count wraps to 0.

Source files
------------

// File: rtl/tri_fifo_writer.sv
// Triangle writer: unpacks an accepted triangle into three vertex/color word-pair writes to two
// downstream FIFOs, and appends three all-ones flush-marker pairs on request.
// Latency: first write lands in the cycle after the transfer; 3 write cycles per triangle minimum.
// Backpressure: both strobes are withheld while either FIFO reports full.
// tri_ready is high only while idle with no pending flush.
//
// Ports:
//   clk, reset             clock and synchronous active-low reset
//   tri_valid / tri_ready  triangle handshake; tri_v0..2 / tri_c0..2 carry the six words
//   flush_req              one-cycle request for an end-of-frame flush marker
//   vertex_full/color_full downstream FIFO full flags
//   vertex_wr_en/_din      vertex FIFO write port (strobe shared with the color port)
//   color_wr_en/_din       color FIFO write port
//   sentinel_err           one-cycle pulse when a sentinel triangle is dropped
//   flush_done             one-cycle pulse after the third flush-marker write
//   tri_count              triangles fully written, wrapping 16-bit count
module tri_fifo_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [95:0] tri_v0,
  input  logic [95:0] tri_v1,
  input  logic [95:0] tri_v2,
  input  logic [95:0] tri_c0,
  input  logic [95:0] tri_c1,
  input  logic [95:0] tri_c2,
  input  logic        flush_req,
  input  logic        vertex_full,
  input  logic        color_full,
  output logic        vertex_wr_en,
  output logic        color_wr_en,
  output logic [95:0] vertex_din,
  output logic [95:0] color_din,
  output logic        sentinel_err,
  output logic        flush_done,
  output logic [15:0] tri_count
);

  localparam logic [95:0] ALL_ONES = {96{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_flush_pending;
  logic [15:0] r_tri_count;
  logic [95:0] r_v0, r_v1, r_v2;
  logic [95:0] r_c0, r_c1, r_c2;
  logic        r_sentinel_err;
  logic        r_flush_done;

  logic        w_room;
  logic        w_wr;
  logic        w_ready;
  logic        w_sentinel;
  logic        w_flush_next;
  logic [95:0] w_vsel;
  logic [95:0] w_csel;

  // Both FIFOs must have room so the pair is always written together.
  assign w_room  = ~vertex_full & ~color_full;
  // Reset gating keeps the handshake and strobes quiet while reset is held.
  assign w_wr    = reset & w_room & ((r_state == ST_WRITE) | (r_state == ST_FLUSH));
  assign w_ready = reset & (r_state == ST_IDLE) & ~r_flush_pending;

  assign w_sentinel   = (tri_v0 == ALL_ONES) && (tri_c0 == ALL_ONES);
  // A request arriving in the same cycle as a sequence end is folded into the next flush.
  assign w_flush_next = r_flush_pending | flush_req;

  always_comb begin
    w_vsel = '0;
    w_csel = '0;
    if (r_state == ST_FLUSH) begin
      w_vsel = ALL_ONES;
      w_csel = ALL_ONES;
    end else begin
      case (r_idx)
        2'd0: begin w_vsel = r_v0; w_csel = r_c0; end
        2'd1: begin w_vsel = r_v1; w_csel = r_c1; end
        2'd2: begin w_vsel = r_v2; w_csel = r_c2; end
        default: begin w_vsel = '0; w_csel = '0; end
      endcase
    end
  end

  assign tri_ready    = w_ready;
  assign vertex_wr_en = w_wr;
  assign color_wr_en  = w_wr;
  assign vertex_din   = w_wr ? w_vsel : '0;
  assign color_din    = w_wr ? w_csel : '0;
  assign sentinel_err = r_sentinel_err;
  assign flush_done   = r_flush_done;
  assign tri_count    = r_tri_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_idx           <= 2'd0;
      r_flush_pending <= 1'b0;
      r_tri_count     <= 16'd0;
      r_v0            <= '0;
      r_v1            <= '0;
      r_v2            <= '0;
      r_c0            <= '0;
      r_c1            <= '0;
      r_c2            <= '0;
      r_sentinel_err  <= 1'b0;
      r_flush_done    <= 1'b0;
    end else begin
      r_sentinel_err <= 1'b0;
      r_flush_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_flush_pending) begin
            // Any request seen this cycle merges into the flush being started.
            r_state         <= ST_FLUSH;
            r_idx           <= 2'd0;
            r_flush_pending <= 1'b0;
          end else begin
            r_flush_pending <= flush_req;
            if (tri_valid) begin
              if (w_sentinel) begin
                r_sentinel_err <= 1'b1;
              end else begin
                r_v0    <= tri_v0;
                r_v1    <= tri_v1;
                r_v2    <= tri_v2;
                r_c0    <= tri_c0;
                r_c1    <= tri_c1;
                r_c2    <= tri_c2;
                r_idx   <= 2'd0;
                r_state <= ST_WRITE;
              end
            end
          end
        end

        ST_WRITE: begin
          r_flush_pending <= w_flush_next;
          if (w_wr) begin
            if (r_idx == 2'd2) begin
              r_tri_count <= r_tri_count + 16'd1;
              r_idx       <= 2'd0;
              // Go straight into the flush so it follows the third write without a gap.
              if (w_flush_next) begin
                r_state         <= ST_FLUSH;
                r_flush_pending <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        ST_FLUSH: begin
          r_flush_pending <= w_flush_next;
          if (w_wr) begin
            if (r_idx == 2'd2) begin
              r_flush_done <= 1'b1;
              r_idx        <= 2'd0;
              if (w_flush_next) begin
                r_flush_pending <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fifo_writer.sv
// Bench for tri_fifo_writer: directed triangles and flushes; expected write pairs go into a
// scoreboard queue when stimulus is issued and a negedge monitor pops and compares each write.
// Directed timing checks cover write cadence, stalls, pulses, reset and counter wrap.
module tb_tri_fifo_writer;

  localparam logic [95:0] ONES = {96{1'b1}};

  typedef struct packed {
    logic [95:0] v;
    logic [95:0] c;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [95:0] tri_v0 = '0, tri_v1 = '0, tri_v2 = '0;
  logic [95:0] tri_c0 = '0, tri_c1 = '0, tri_c2 = '0;
  logic        flush_req = 1'b0;
  logic        vertex_full = 1'b0;
  logic        color_full = 1'b0;
  logic        vertex_wr_en, color_wr_en;
  logic [95:0] vertex_din, color_din;
  logic        sentinel_err, flush_done;
  logic [15:0] tri_count;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  tri_fifo_writer dut (
    .clk(clk), .reset(reset),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
    .tri_c0(tri_c0), .tri_c1(tri_c1), .tri_c2(tri_c2),
    .flush_req(flush_req),
    .vertex_full(vertex_full), .color_full(color_full),
    .vertex_wr_en(vertex_wr_en), .color_wr_en(color_wr_en),
    .vertex_din(vertex_din), .color_din(color_din),
    .sentinel_err(sentinel_err), .flush_done(flush_done),
    .tri_count(tri_count)
  );

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every write must be a paired strobe into non-full FIFOs carrying the next
  // expected pair; idle cycles must present zero data.
  always @(negedge clk) begin
    pair_t e;
    if (vertex_wr_en !== color_wr_en) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_pair: vertex_wr_en=%0b color_wr_en=%0b expected equal",
               vertex_wr_en, color_wr_en);
    end else if (vertex_wr_en === 1'b1) begin
      chk1("wr_gated", vertex_full | color_full, 1'b0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got v=%h c=%h expected no write", vertex_din, color_din);
      end else begin
        e = exp_q.pop_front();
        if (vertex_din !== e.v || color_din !== e.c) begin
          n_errors++;
          $display("FAIL wr_data: got v=%h c=%h expected v=%h c=%h",
                   vertex_din, color_din, e.v, e.c);
        end
      end
    end else begin
      n_checks++;
      if (vertex_din !== '0 || color_din !== '0) begin
        n_errors++;
        $display("FAIL idle_din: got v=%h c=%h expected 0", vertex_din, color_din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [95:0] v, input logic [95:0] c);
    pair_t p;
    p.v = v;
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Offers a triangle, waits (bounded) for tri_ready, and returns 1 ns after the transfer edge.
  task automatic send_tri(input logic [95:0] v0, input logic [95:0] v1, input logic [95:0] v2,
                          input logic [95:0] c0, input logic [95:0] c1, input logic [95:0] c2,
                          input logic with_flush, input logic is_drop);
    int waited = 0;
    tri_v0 = v0; tri_v1 = v1; tri_v2 = v2;
    tri_c0 = c0; tri_c1 = c1; tri_c2 = c2;
    tri_valid = 1'b1;
    while (tri_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (tri_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: tri_ready=%0b after %0d cycles expected 1", tri_ready, waited);
      tri_valid = 1'b0;
      return;
    end
    flush_req = with_flush;
    if (!is_drop) begin
      push(v0, c0);
      push(v1, c1);
      push(v2, c2);
    end
    if (with_flush) begin
      for (int k = 0; k < 3; k++) push(ONES, ONES);
    end
    tick();
    tri_valid = 1'b0;
    flush_req = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt;

    // Reset state
    tri_valid = 1'b1;
    tick(); tick(); tick();
    chk1("rst_tri_ready", tri_ready, 1'b0);
    chk1("rst_wr_en", vertex_wr_en | color_wr_en, 1'b0);
    chk16("rst_tri_count", tri_count, 16'd0);
    chk1("rst_sentinel", sentinel_err, 1'b0);
    chk1("rst_flush_done", flush_done, 1'b0);
    tri_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk1("ready_after_rst", tri_ready, 1'b1);

    // One triangle, FIFOs never full: three back-to-back writes
    send_tri(96'd1, 96'd2, 96'd3, 96'd4, 96'd5, 96'd6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("t1_wr%0d", k), vertex_wr_en, 1'b1);
      tick();
    end
    @(negedge clk);
    chk1("t1_idle", vertex_wr_en, 1'b0);
    chk16("t1_count", tri_count, 16'd1);
    tick();

    // Color FIFO full for 4 cycles during the second write
    send_tri(96'd7, 96'd8, 96'd9, 96'd10, 96'd11, 96'd12, 1'b0, 1'b0);
    @(negedge clk);
    chk1("t2_wr0", vertex_wr_en, 1'b1);
    tick();
    color_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("t2_hold%0d", k), vertex_wr_en, 1'b0);
      tick();
    end
    color_full = 1'b0;
    @(negedge clk);
    chk1("t2_resume", vertex_wr_en, 1'b1);
    tick();
    @(negedge clk);
    chk1("t2_last", vertex_wr_en, 1'b1);
    tick();
    @(negedge clk);
    chk1("t2_idle", vertex_wr_en, 1'b0);
    chk16("t2_count", tri_count, 16'd2);
    tick();

    // Triangle and flush in the same cycle: 3 triangle writes, 3 marker writes, flush_done
    send_tri(96'd13, 96'd14, 96'd15, 96'd16, 96'd17, 96'd18, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1($sformatf("t3_wr%0d", k), vertex_wr_en, 1'b1);
      chk1($sformatf("t3_fd_low%0d", k), flush_done, 1'b0);
      tick();
    end
    @(negedge clk);
    chk1("t3_idle", vertex_wr_en, 1'b0);
    chk1("t3_flush_done", flush_done, 1'b1);
    tick();
    @(negedge clk);
    chk1("t3_fd_pulse", flush_done, 1'b0);
    chk16("t3_count", tri_count, 16'd3);
    chk1("t3_ready", tri_ready, 1'b1);
    tick();

    // Second flush request during a flush merges into exactly one more flush
    for (int k = 0; k < 6; k++) push(ONES, ONES);
    fd_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      flush_req = (k == 0 || k == 3);
      @(negedge clk);
      if (flush_done === 1'b1) fd_cnt++;
      tick();
    end
    flush_req = 1'b0;
    chk16("t3b_fd_pulses", 16'(fd_cnt), 16'd2);
    chk16("t3b_count", tri_count, 16'd3);

    // Sentinel triangle is dropped
    send_tri(ONES, 96'd1, 96'd2, ONES, 96'd3, 96'd4, 1'b0, 1'b1);
    @(negedge clk);
    chk1("t4_sentinel", sentinel_err, 1'b1);
    chk1("t4_ready", tri_ready, 1'b1);
    chk1("t4_no_wr", vertex_wr_en, 1'b0);
    tick();
    @(negedge clk);
    chk1("t4_sentinel_pulse", sentinel_err, 1'b0);
    chk16("t4_count", tri_count, 16'd3);
    tick();

    // Reset after the first write of a triangle abandons the rest
    send_tri(96'd21, 96'd22, 96'd23, 96'd24, 96'd25, 96'd26, 1'b0, 1'b0);
    @(negedge clk);
    chk1("t5_wr0", vertex_wr_en, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("t5_rst_wr_a", vertex_wr_en | color_wr_en, 1'b0);
    tick();
    @(negedge clk);
    chk1("t5_rst_wr_b", vertex_wr_en | color_wr_en, 1'b0);
    chk1("t5_rst_ready", tri_ready, 1'b0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk1("t5_ready", tri_ready, 1'b1);
    chk1("t5_no_wr", vertex_wr_en, 1'b0);
    chk16("t5_count", tri_count, 16'd0);
    tick();

    // Counter wrap: 65535 triangles reach FFFF, one more wraps to 0
    for (int i = 0; i < 65535; i++) begin
      send_tri({32'(i), 64'd1}, {32'(i), 64'd2}, {32'(i), 64'd3},
               {32'(i), 64'd4}, {32'(i), 64'd5}, {32'(i), 64'd6}, 1'b0, 1'b0);
    end
    tick(); tick(); tick();
    chk16("t6_count_max", tri_count, 16'hFFFF);
    send_tri(96'd31, 96'd32, 96'd33, 96'd34, 96'd35, 96'd36, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk16("t6_count_wrap", tri_count, 16'd0);
    tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_writes: got %0d pending pairs expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
